// File: rtl/srl_test_sequencer_pkg.sv
// Shared types and width helpers for the SRL test sequencer.
package srl_test_sequencer_pkg;

  // Sequencer phases: testers held in reset, settling window, live checking.
  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    GUARD = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Default geometry used by the top and the interface.
  localparam int DEF_NUM_CHANNELS = 8;
  localparam int DEF_CNT_WIDTH    = 8;

  // Counter width able to hold the value 'limit' itself.
  function automatic int cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

  // Largest value a w-bit saturating counter may hold (w < 32).
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/srl_test_sequencer_if.sv
// Board/tester-facing signal bundle of the SRL test sequencer.
interface srl_test_sequencer_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int CNT_WIDTH    = 8
);
  localparam int SEL_W = $clog2(NUM_CHANNELS);

  logic                    tst_rst;
  logic                    tst_ce;
  logic [NUM_CHANNELS-1:0] error_in;
  logic                    clear;
  logic [SEL_W-1:0]        sel;
  logic [CNT_WIDTH-1:0]    sel_count;
  logic                    sel_sticky;
  logic                    any_error;
  logic                    running;
  logic                    heartbeat;

  // The sequencer itself.
  modport slave (
    input  error_in, clear, sel,
    output tst_rst, tst_ce, sel_count, sel_sticky, any_error, running, heartbeat
  );

  // Whoever drives the error flags and reads status.
  modport master (
    output error_in, clear, sel,
    input  tst_rst, tst_ce, sel_count, sel_sticky, any_error, running, heartbeat
  );
endinterface

// File: rtl/srl_test_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over inc.
module sat_counter
  import srl_test_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] MAX = W'(sat_max(W));

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step up and stick at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != MAX) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/srl_test_sequencer.sv
// SRL test sequencer: tester reset/strobe generation, per-channel error
// accounting and a registered status readout.
module srl_test_sequencer
  import srl_test_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS   = DEF_NUM_CHANNELS,
  parameter int CE_DIVIDE      = 4,
  parameter int STARTUP_CYCLES = 16,
  parameter int GUARD_CYCLES   = 8,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int HB_BITS        = 6
) (
  input logic                 clk,
  input logic                 rst,
  srl_test_sequencer_if.slave bus
);
  localparam int SEL_W   = $clog2(NUM_CHANNELS);
  localparam int HOLD_W  = cnt_w(STARTUP_CYCLES);
  localparam int GUARD_W = cnt_w(GUARD_CYCLES);
  localparam int DIV_W   = $clog2(CE_DIVIDE);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(STARTUP_CYCLES - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CE_DIVIDE - 1);

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [GUARD_W-1:0]    guard_cnt_q, guard_cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  tst_rst_q, tst_rst_d;
  logic                  tst_ce_q, tst_ce_d;
  logic                  running_q, running_d;
  logic [HB_BITS-1:0]    hb_cnt_q, hb_cnt_d;
  logic                  hb_q, hb_d;
  logic [NUM_CHANNELS-1:0] sticky_q, sticky_d;
  logic                  any_error_q, any_error_d;
  logic [CNT_WIDTH-1:0]  sel_count_q, sel_count_d;
  logic                  sel_sticky_q, sel_sticky_d;

  logic [NUM_CHANNELS-1:0]                inc;
  logic [NUM_CHANNELS-1:0][CNT_WIDTH-1:0] cnt;

  // Phase sequencing; tst_rst/running follow the next state so they change
  // on the same edge as the transition.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d    = GUARD;
        else                         hold_cnt_d = hold_cnt_q + 1'b1;
      end
      GUARD: begin
        if (guard_cnt_q == GUARD_LAST) state_d     = RUN;
        else                           guard_cnt_d = guard_cnt_q + 1'b1;
      end
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
    tst_rst_d = (state_d == HOLD);
    running_d = (state_d == RUN);
  end

  // Strobe divider (frozen in HOLD, free-running afterwards) and heartbeat.
  always_comb begin
    div_d    = '0;
    tst_ce_d = 1'b0;
    if (state_q != HOLD) begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tst_ce_d = (div_q == DIV_LAST);
    end
    hb_cnt_d = hb_cnt_q;
    hb_d     = hb_q;
    if (tst_ce_q) begin
      hb_cnt_d = hb_cnt_q + 1'b1;
      if (hb_cnt_q == '1) hb_d = ~hb_q;
    end
  end

  // Error capture only in RUN; clear beats a same-cycle error.
  always_comb begin
    inc         = (state_q == RUN) ? bus.error_in : '0;
    sticky_d    = bus.clear ? '0 : (sticky_q | inc);
    any_error_d = |sticky_q;
  end

  // Readout mux; out-of-range selects fall through to zero.
  always_comb begin
    sel_count_d  = '0;
    sel_sticky_d = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (bus.sel == SEL_W'(i)) begin
        sel_count_d  = cnt[i];
        sel_sticky_d = sticky_q[i];
      end
    end
  end

  // Sequencer state, divider and heartbeat registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD;
      hold_cnt_q  <= '0;
      guard_cnt_q <= '0;
      div_q       <= '0;
      tst_rst_q   <= 1'b1;
      tst_ce_q    <= 1'b0;
      running_q   <= 1'b0;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      div_q       <= div_d;
      tst_rst_q   <= tst_rst_d;
      tst_ce_q    <= tst_ce_d;
      running_q   <= running_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
    end
  end

  // Sticky flags and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q     <= '0;
      any_error_q  <= 1'b0;
      sel_count_q  <= '0;
      sel_sticky_q <= 1'b0;
    end else begin
      sticky_q     <= sticky_d;
      any_error_q  <= any_error_d;
      sel_count_q  <= sel_count_d;
      sel_sticky_q <= sel_sticky_d;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    sat_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.clear),
      .inc (inc[i]),
      .cnt (cnt[i])
    );
  end

  assign bus.tst_rst    = tst_rst_q;
  assign bus.tst_ce     = tst_ce_q;
  assign bus.running    = running_q;
  assign bus.heartbeat  = hb_q;
  assign bus.any_error  = any_error_q;
  assign bus.sel_count  = sel_count_q;
  assign bus.sel_sticky = sel_sticky_q;
endmodule

// File: tb/tb_srl_test_sequencer.sv
// Scoreboard bench for srl_test_sequencer (6 channels so that sel can go out
// of range). Expected outputs come from cycle-count arithmetic and plain
// per-channel arrays, queued by the driver and checked by a negedge monitor.
module tb_srl_test_sequencer;
  localparam int NCH = 6;
  localparam int CW  = 8;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  srl_test_sequencer_if #(.NUM_CHANNELS(NCH), .CNT_WIDTH(CW)) bus ();

  srl_test_sequencer #(
    .NUM_CHANNELS(NCH), .CE_DIVIDE(4), .STARTUP_CYCLES(16),
    .GUARD_CYCLES(8), .CNT_WIDTH(CW), .HB_BITS(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int cyc;
    bit tst_rst, tst_ce, running, hb, any, stk;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   t;            // cycles since reset release
  int   m_cnt[NCH];
  bit   m_sticky[NCH];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, t);
    end
  endtask

  // Timing-only outputs from the cycle number: 16 reset cycles, 8 guard
  // cycles, first strobe 4 cycles into guard, heartbeat every 64 strobes.
  function automatic exp_t timing(input int c);
    exp_t e;
    int pulses;
    e = '{default: 0};
    e.cyc     = c;
    e.tst_rst = (c < 16);
    e.running = (c >= 24);
    e.tst_ce  = (c >= 20) && ((c - 20) % 4 == 0);
    pulses    = (c > 20) ? (c - 17) / 4 : 0;
    e.hb      = ((pulses / 64) % 2) == 1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_sticky[i] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be next cycle.
  task automatic run_cycle(input logic [NCH-1:0] err, input bit clr, input int s);
    exp_t e;
    bus.error_in = err;
    bus.clear    = clr;
    bus.sel      = 3'(s);
    e = timing(t + 1);
    e.cnt = (s < NCH) ? m_cnt[s] : 0;
    e.stk = (s < NCH) ? m_sticky[s] : 1'b0;
    e.any = 1'b0;
    for (int i = 0; i < NCH; i++) e.any = e.any | m_sticky[i];
    q.push_back(e);
    if (clr) model_reset();
    else if (t >= 24) begin
      for (int i = 0; i < NCH; i++) begin
        if (err[i]) begin
          m_sticky[i] = 1'b1;
          if (m_cnt[i] < MAXC) m_cnt[i]++;
        end
      end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  // Monitor: compare the queued expectation for the current cycle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc <= t) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc != t) chk("stale_entry", e.cyc, t);
      else begin
        chk("tst_rst",    int'(bus.tst_rst),    int'(e.tst_rst));
        chk("tst_ce",     int'(bus.tst_ce),     int'(e.tst_ce));
        chk("running",    int'(bus.running),    int'(e.running));
        chk("heartbeat",  int'(bus.heartbeat),  int'(e.hb));
        chk("any_error",  int'(bus.any_error),  int'(e.any));
        chk("sel_count",  int'(bus.sel_count),  e.cnt);
        chk("sel_sticky", int'(bus.sel_sticky), int'(e.stk));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_tst_rst"},   int'(bus.tst_rst),    1);
    chk({tag, "_tst_ce"},    int'(bus.tst_ce),     0);
    chk({tag, "_running"},   int'(bus.running),    0);
    chk({tag, "_heartbeat"}, int'(bus.heartbeat),  0);
    chk({tag, "_any_error"}, int'(bus.any_error),  0);
    chk({tag, "_sel_count"}, int'(bus.sel_count),  0);
    chk({tag, "_sel_stk"},   int'(bus.sel_sticky), 0);
  endtask

  initial begin
    t = 0;
    bus.error_in = '0;
    bus.clear    = 1'b0;
    bus.sel      = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // HOLD/GUARD with random errors, which must all be ignored.
    for (int i = 0; i < 24; i++)
      run_cycle(6'($urandom) | 6'h01, 1'b0, $urandom_range(0, 7));

    // Three error pulses on channel 0 in RUN.
    repeat (3) run_cycle(6'h01, 1'b0, 0);
    repeat (3) run_cycle(6'h00, 1'b0, 0);

    // Random sparse errors, occasional clears, in- and out-of-range sel.
    for (int i = 0; i < 60; i++)
      run_cycle(($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00,
                $urandom_range(0, 19) == 0, $urandom_range(0, 7));

    // Channel 5 held for 300 cycles: saturation, others untouched.
    run_cycle(6'h00, 1'b1, 5);
    for (int i = 0; i < 300; i++)
      run_cycle(6'h20, 1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 5);
    repeat (2) run_cycle(6'h00, 1'b0, 5);

    // Clear colliding with an error on channel 2 holding count 7.
    run_cycle(6'h00, 1'b1, 2);
    repeat (7) run_cycle(6'h04, 1'b0, 2);
    run_cycle(6'h04, 1'b1, 2);
    repeat (3) run_cycle(6'h00, 1'b0, 2);

    // Leave non-zero counts before the mid-run reset.
    repeat (5) run_cycle(6'h3f, 1'b0, $urandom_range(0, 7));
    repeat (2) run_cycle(6'h00, 1'b0, 1);

    // Drain, then reset asynchronously in the middle of a cycle.
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    model_reset();

    // Second startup, long enough for 64+ strobes (heartbeat toggle).
    for (int i = 0; i < 300; i++)
      run_cycle(($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00,
                $urandom_range(0, 39) == 0, $urandom_range(0, 7));

    @(negedge clk);
    #1;
    chk("queue_drained_end", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
